// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: open-page DRAM command scheduler (PRE/ACT/column), one request in flight.
// Latency: hit = 1+A+D+T_CAS cycles from accept edge to rsp_valid; a miss adds a PRE and/or ACT phase.
// Backpressure: req_ready only in IDLE; every command waits on a four-phase cmd_req/cmd_ack handshake.
// Ports: req_* (translated request in), cmd_* (DRAM command handshake), rsp_valid/rsp_rw (completion pulse).
module dram_cmd_sched #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 3,
  parameter int T_CAS        = 2,
  localparam int BW          = $clog2(NUM_OF_BANKS),
  localparam int RW          = $clog2(NUM_OF_ROWS),
  localparam int CW          = $clog2(NUM_OF_COLS)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rw,
  input  logic [BW-1:0] req_bank,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  output logic          cmd_req,
  input  logic          cmd_ack,
  output logic [1:0]    cmd,
  output logic [BW-1:0] cmd_bank,
  output logic [RW-1:0] cmd_row,
  output logic [CW-1:0] cmd_col,
  output logic          rsp_valid,
  output logic          rsp_rw
);

  localparam int TMAX = (T_RCD > T_RP) ? ((T_RCD > T_CAS) ? T_RCD : T_CAS)
                                       : ((T_RP  > T_CAS) ? T_RP  : T_CAS);
  localparam int CNTW = $clog2(TMAX + 1);

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [3:0] {
    IDLE, PRE_REQ, PRE_REL, PRE_WAIT, ACT_REQ, ACT_REL, ACT_WAIT, COL_REQ, COL_REL, COL_WAIT
  } state_t;

  state_t state, state_nxt;

  logic            lat_rw;
  logic [BW-1:0]   lat_bank;
  logic [RW-1:0]   lat_row;
  logic [CW-1:0]   lat_col;
  logic [CNTW-1:0] cnt;

  logic [NUM_OF_BANKS-1:0] open_vld;
  logic [RW-1:0]           open_row [NUM_OF_BANKS];

  logic          in_idle, is_req, is_wait, ack_done, hit, issue;
  logic          src_rw;
  logic [BW-1:0] src_bank;
  logic [RW-1:0] src_row;
  logic [CW-1:0] src_col;
  logic [1:0]    issue_cmd;

  assign in_idle   = (state == IDLE);
  assign is_req    = (state inside {PRE_REQ, ACT_REQ, COL_REQ});
  assign is_wait   = (state inside {PRE_WAIT, ACT_WAIT, COL_WAIT});
  // An ack only counts once our own cmd_req is up, so a stale ack left high is ignored.
  assign ack_done  = is_req && cmd_req && cmd_ack;
  assign hit       = open_vld[req_bank] && (open_row[req_bank] == req_row);
  assign req_ready = in_idle && !rst_b;

  // The first command of a request is loaded from the live inputs (latches update on the same edge).
  assign src_rw   = in_idle ? req_rw   : lat_rw;
  assign src_bank = in_idle ? req_bank : lat_bank;
  assign src_row  = in_idle ? req_row  : lat_row;
  assign src_col  = in_idle ? req_col  : lat_col;
  assign issue    = (state_nxt != state) && (state_nxt inside {PRE_REQ, ACT_REQ, COL_REQ});

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (hit)                     state_nxt = COL_REQ;
          else if (open_vld[req_bank]) state_nxt = PRE_REQ;
          else                         state_nxt = ACT_REQ;
        end
      end
      PRE_REQ:  if (ack_done)   state_nxt = PRE_REL;
      PRE_REL:  if (!cmd_ack)   state_nxt = PRE_WAIT;
      PRE_WAIT: if (cnt == '0)  state_nxt = ACT_REQ;
      ACT_REQ:  if (ack_done)   state_nxt = ACT_REL;
      ACT_REL:  if (!cmd_ack)   state_nxt = ACT_WAIT;
      ACT_WAIT: if (cnt == '0)  state_nxt = COL_REQ;
      COL_REQ:  if (ack_done)   state_nxt = COL_REL;
      COL_REL:  if (!cmd_ack)   state_nxt = COL_WAIT;
      COL_WAIT: if (cnt == '0)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_cmd = CMD_ACT;
    case (state_nxt)
      PRE_REQ: issue_cmd = CMD_PRE;
      COL_REQ: issue_cmd = src_rw ? CMD_WR : CMD_RD;
      default: issue_cmd = CMD_ACT;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      lat_rw    <= 1'b0;
      lat_bank  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      cmd_req   <= 1'b0;
      cmd       <= CMD_ACT;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b0;
      open_vld  <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) open_row[i] <= '0;
    end else begin
      if (in_idle && req_valid) begin
        lat_rw   <= req_rw;
        lat_bank <= req_bank;
        lat_row  <= req_row;
        lat_col  <= req_col;
      end

      // Command fields change only when a new command is issued and hold afterwards.
      if (issue) begin
        cmd      <= issue_cmd;
        cmd_bank <= src_bank;
        cmd_row  <= src_row;
        cmd_col  <= src_col;
      end

      // cmd_req rises one cycle into X_REQ, and only once cmd_ack is seen low.
      if (is_req && !cmd_req && !cmd_ack) cmd_req <= 1'b1;
      else if (ack_done)                  cmd_req <= 1'b0;

      if (state == PRE_REL && !cmd_ack)      cnt <= CNTW'(T_RP - 1);
      else if (state == ACT_REL && !cmd_ack) cnt <= CNTW'(T_RCD - 1);
      else if (state == COL_REL && !cmd_ack) cnt <= CNTW'(T_CAS - 1);
      else if (is_wait && cnt != '0)         cnt <= cnt - CNTW'(1);

      rsp_valid <= (state == COL_WAIT) && (cnt == '0);
      if ((state == COL_WAIT) && (cnt == '0)) rsp_rw <= lat_rw;

      if ((state == PRE_REQ) && ack_done) open_vld[lat_bank] <= 1'b0;
      if ((state == ACT_REQ) && ack_done) begin
        open_vld[lat_bank] <= 1'b1;
        open_row[lat_bank] <= lat_row;
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// tb_dram_cmd_sched: directed bench for dram_cmd_sched with a small DRAM handshake responder.
// Latency: expected completion latencies are hand-computed as 1+A+D+T per command phase.
// Backpressure: responder acks A cycles after cmd_req rises and drops ack D cycles after it falls.
module tb_dram_cmd_sched;

  logic       clk, rst_b;
  logic       req_valid, req_ready, req_rw;
  logic [2:0] req_bank;
  logic [6:0] req_row;
  logic [2:0] req_col;
  logic       cmd_req, cmd_ack;
  logic [1:0] cmd;
  logic [2:0] cmd_bank;
  logic [6:0] cmd_row;
  logic [2:0] cmd_col;
  logic       rsp_valid, rsp_rw;

  typedef struct packed {
    logic [1:0] c;
    logic [2:0] b;
    logic [6:0] r;
    logic [2:0] col;
  } ent_t;

  ent_t log_q[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   ack_dly  = 1;
  int   rel_dly  = 1;
  bit   auto_ack = 1'b1;
  int   req_during_hold = 0;

  dram_cmd_sched dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd(cmd),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DRAM side: log each command, ack after ack_dly cycles, release rel_dly cycles after cmd_req falls.
  initial begin
    cmd_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (auto_ack && cmd_req && !rst_b) begin
        log_q.push_back('{cmd, cmd_bank, cmd_row, cmd_col});
        repeat (ack_dly - 1) begin @(posedge clk); #1; end
        cmd_ack = 1'b1;
        do begin @(posedge clk); #1; end while (cmd_req);
        repeat (rel_dly - 1) begin
          @(posedge clk); #1;
          if (cmd_req) req_during_hold++;
        end
        cmd_ack = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ent(input string tag, input int idx, input ent_t exp);
    ent_t e;
    e = (idx < log_q.size()) ? log_q[idx] : 'x;
    check(tag, 32'(e), 32'(exp));
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (!req_ready && i < 50) begin @(posedge clk); #1; i++; end
    check("wait_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_rsp(output int lat, output logic rw);
    bit done;
    done = 1'b0;
    lat  = 0;
    rw   = 1'bx;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) begin
        rw   = rsp_rw;
        done = 1'b1;
      end
    end
    if (!done) lat = -1;
  endtask

  task automatic send(input string tag, input logic rw, input logic [2:0] b, input logic [6:0] r,
                      input logic [2:0] c, input int exp_lat);
    int   lat;
    logic got_rw;
    wait_ready();
    req_valid = 1'b1; req_rw = rw; req_bank = b; req_row = r; req_col = c;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_ready_after_accept"}, 32'(req_ready), 32'd0);
    wait_rsp(lat, got_rw);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_rw"}, 32'(got_rw), 32'(rw));
  endtask

  initial begin
    int   lat;
    logic got_rw;
    int   rsp_seen;

    rst_b = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_bank = '0; req_row = '0; req_col = '0;

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_cmd_req",   32'(cmd_req),   32'd0);
    check("rst_cmd",       32'(cmd),       32'd0);
    check("rst_cmd_addr",  32'({cmd_bank, cmd_row, cmd_col}), 32'd0);
    check("rst_rsp",       32'({rsp_valid, rsp_rw}), 32'd0);
    rst_b = 1'b0;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Closed bank write: ACT then WR, 1+1+1+3 + 1+1+1+2 = 11
    log_q.delete();
    send("closed", 1'b1, 3'd5, 7'h2A, 3'd3, 11);
    check("closed_ncmd", log_q.size(), 2);
    check_ent("closed_act", 0, '{2'b00, 3'd5, 7'h2A, 3'd3});
    check_ent("closed_wr",  1, '{2'b10, 3'd5, 7'h2A, 3'd3});

    // Row hit read: single RD, 1+1+1+2 = 5, one-cycle pulse
    log_q.delete();
    send("hit", 1'b0, 3'd5, 7'h2A, 3'd7, 5);
    @(posedge clk); #1;
    check("hit_pulse_one_cycle", 32'(rsp_valid), 32'd0);
    check("hit_ncmd", log_q.size(), 1);
    check_ent("hit_rd", 0, '{2'b01, 3'd5, 7'h2A, 3'd7});

    // Row miss: PRE, ACT, RD = 6 + 6 + 5 = 17
    log_q.delete();
    send("miss", 1'b0, 3'd5, 7'h10, 3'd1, 17);
    check("miss_ncmd", log_q.size(), 3);
    check_ent("miss_pre", 0, '{2'b11, 3'd5, 7'h10, 3'd1});
    check_ent("miss_act", 1, '{2'b00, 3'd5, 7'h10, 3'd1});
    check_ent("miss_rd",  2, '{2'b01, 3'd5, 7'h10, 3'd1});
    log_q.delete();
    send("miss_repeat", 1'b0, 3'd5, 7'h10, 3'd1, 5);
    check("miss_repeat_ncmd", log_q.size(), 1);
    check_ent("miss_repeat_rd", 0, '{2'b01, 3'd5, 7'h10, 3'd1});

    // Bank independence
    send("open_b0", 1'b0, 3'd0, 7'h01, 3'd0, 11);
    send("open_b7", 1'b0, 3'd7, 7'h02, 3'd0, 11);
    log_q.delete();
    send("indep_hit", 1'b0, 3'd0, 7'h01, 3'd6, 5);
    check("indep_ncmd", log_q.size(), 1);
    check_ent("indep_rd", 0, '{2'b01, 3'd0, 7'h01, 3'd6});

    // Ack held 5 extra cycles: D = 6, hit latency 1+1+6+2 = 10
    log_q.delete();
    rel_dly = 6;
    send("abuse", 1'b0, 3'd7, 7'h02, 3'd4, 10);
    rel_dly = 1;
    check("abuse_req_low_during_hold", req_during_hold, 0);
    check("abuse_ncmd", log_q.size(), 1);

    // req_valid held through a busy request; second one accepted only after rsp_valid
    log_q.delete();
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b0; req_bank = 3'd7; req_row = 7'h02; req_col = 3'd0;
    @(posedge clk); #1;
    check("busy_ready_low", 32'(req_ready), 32'd0);
    req_rw = 1'b1; req_bank = 3'd0; req_row = 7'h01; req_col = 3'd5;
    wait_rsp(lat, got_rw);
    check("busy_first_latency", lat, 5);
    check("busy_first_rw", 32'(got_rw), 32'd0);
    check("b2b_ready_with_rsp", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat, got_rw);
    check("b2b_second_latency", lat, 5);
    check("b2b_second_rw", 32'(got_rw), 32'd1);
    check("busy_ncmd", log_q.size(), 2);
    check_ent("busy_rd", 0, '{2'b01, 3'd7, 7'h02, 3'd0});
    check_ent("busy_wr", 1, '{2'b10, 3'd0, 7'h01, 3'd5});

    // Reset while a column command is pending with no ack
    auto_ack = 1'b0;
    log_q.delete();
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b0; req_bank = 3'd0; req_row = 7'h01; req_col = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("pend_cmd_req", 32'(cmd_req), 32'd1);
    check("pend_cmd_rd",  32'(cmd),     32'd1);
    rst_b = 1'b1;
    #1;
    check("midrst_cmd_req_async", 32'(cmd_req), 32'd0);
    rsp_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    rst_b = 1'b0;
    auto_ack = 1'b1;
    check("midrst_no_rsp", rsp_seen, 0);
    send("after_rst", 1'b0, 3'd0, 7'h01, 3'd2, 11);
    check("after_rst_ncmd", log_q.size(), 2);
    check_ent("after_rst_act", 0, '{2'b00, 3'd0, 7'h01, 3'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
